// File: rtl/qspi_flash_read_ctrl.sv
// Quad-I/O fast-read (0xEB) sequencer for the board QSPI flash.
// Drives CE_n/SCLK/DQ and streams read bytes back to the requester.
module qspi_flash_read_ctrl #(
    parameter int CLK_DIV     = 2,
    parameter int DUMMY_CLKS  = 4,
    parameter int CS_GAP_CLKS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_len,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        busy,
    output logic        flash_sclk,
    output logic        flash_ce_n,
    output logic [3:0]  flash_dq_out,
    output logic [3:0]  flash_dq_oe,
    input  logic [3:0]  flash_dq_in
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, MODE, DUMMY, DATA, CS_HOLD, CS_GAP
    } state_t;

    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] DUMMY_LAST = 16'(DUMMY_CLKS - 1);
    localparam logic [15:0] GAP_LAST   = 16'(CS_GAP_CLKS - 1);
    localparam logic [7:0]  CMD_QIOR   = 8'hEB;

    state_t      state, state_nx;
    logic [15:0] div_cnt;
    logic [15:0] cnt;
    logic [15:0] byte_cnt;
    logic [31:0] sh;
    logic [3:0]  hi_nib;
    logic        sclk;
    logic        shifting, tick, rise, fall;
    logic [15:0] ph_last;
    logic        ph_end;

    assign shifting = (state == CMD) || (state == ADDR) || (state == MODE)
                   || (state == DUMMY) || (state == DATA);
    assign tick = shifting && (div_cnt == DIV_LAST);
    assign rise = tick && !sclk;
    assign fall = tick && sclk;

    // Last SCLK index of each phase; DATA restarts per byte.
    always_comb begin
        ph_last = 16'd0;
        unique case (state)
            CMD:     ph_last = 16'd7;
            ADDR:    ph_last = 16'd5;
            MODE:    ph_last = 16'd1;
            DUMMY:   ph_last = DUMMY_LAST;
            DATA:    ph_last = 16'd1;
            default: ph_last = 16'd0;
        endcase
    end

    assign ph_end = fall && (cnt == ph_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx = (req_len == 16'd0) ? CS_GAP : CMD;
                end
            end
            CMD:     if (ph_end) state_nx = ADDR;
            ADDR:    if (ph_end) state_nx = MODE;
            MODE:    if (ph_end) state_nx = DUMMY;
            DUMMY:   if (ph_end) state_nx = DATA;
            DATA:    if (ph_end && byte_cnt == 16'd1) state_nx = CS_HOLD;
            CS_HOLD: if (div_cnt == DIV_LAST) state_nx = CS_GAP;
            CS_GAP:  if (cnt == GAP_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            cnt      <= '0;
            byte_cnt <= '0;
            sh       <= '0;
            hi_nib   <= '0;
            sclk     <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (state == IDLE) begin
                // A zero-length accept jumps straight to the last gap cycle.
                div_cnt  <= '0;
                sclk     <= 1'b0;
                cnt      <= (req_len == 16'd0) ? GAP_LAST : 16'd0;
                sh       <= {CMD_QIOR, req_addr};
                byte_cnt <= req_len;
            end else if (shifting) begin
                div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
                if (tick) begin
                    sclk <= !sclk;
                end
                if (rise && state == DATA) begin
                    if (cnt == 16'd0) begin
                        hi_nib <= flash_dq_in;
                    end else begin
                        rd_data  <= {hi_nib, flash_dq_in};
                        rd_valid <= 1'b1;
                    end
                end
                if (fall) begin
                    cnt <= ph_end ? 16'd0 : cnt + 16'd1;
                    if (state == CMD) begin
                        sh <= sh << 1;
                    end
                    if (state == ADDR) begin
                        sh <= sh << 4;
                    end
                    if (state == DATA && ph_end) begin
                        byte_cnt <= byte_cnt - 16'd1;
                    end
                end
            end else if (state == CS_HOLD) begin
                div_cnt <= (div_cnt == DIV_LAST) ? 16'd0 : div_cnt + 16'd1;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    always_comb begin
        flash_dq_out = 4'h0;
        flash_dq_oe  = 4'h0;
        unique case (state)
            CMD: begin
                flash_dq_out = {2'b11, 1'b0, sh[31]};
                flash_dq_oe  = 4'b1101;
            end
            ADDR: begin
                flash_dq_out = sh[31:28];
                flash_dq_oe  = 4'hF;
            end
            MODE: begin
                flash_dq_out = 4'h0;
                flash_dq_oe  = 4'hF;
            end
            default: begin
                flash_dq_out = 4'h0;
                flash_dq_oe  = 4'h0;
            end
        endcase
    end

    assign flash_sclk = sclk;
    assign flash_ce_n = (state == IDLE) || (state == CS_GAP);
    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign done       = (state == CS_GAP) && (cnt == GAP_LAST);

endmodule

// File: tb/tb_qspi_flash_read_ctrl.sv
// Bench for qspi_flash_read_ctrl: behavioural flash model plus
// scoreboard of expected read bytes, with randomized requests.
module tb_qspi_flash_read_ctrl;

    localparam int CLK_DIV = 2;
    localparam int DUMMY   = 4;
    localparam int CS_GAP  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [15:0] req_len;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        done;
    logic        busy;
    logic        flash_sclk;
    logic        flash_ce_n;
    logic [3:0]  flash_dq_out;
    logic [3:0]  flash_dq_oe;
    logic [3:0]  flash_dq_in;

    qspi_flash_read_ctrl #(
        .CLK_DIV    (CLK_DIV),
        .DUMMY_CLKS (DUMMY),
        .CS_GAP_CLKS(CS_GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .done        (done),
        .busy        (busy),
        .flash_sclk  (flash_sclk),
        .flash_ce_n  (flash_ce_n),
        .flash_dq_out(flash_dq_out),
        .flash_dq_oe (flash_dq_oe),
        .flash_dq_in (flash_dq_in)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] seed;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (a == 24'h123456) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ seed;
    endfunction

    // Flash model: decodes command/address/mode, serves data nibbles.
    int          rises;
    logic [7:0]  m_cmd;
    logic [23:0] m_addr;
    logic [7:0]  m_mode;
    logic        drive_en = 1'b0;
    logic [3:0]  drive_nib = 4'h0;
    int          log_edges[$];
    logic [7:0]  log_cmd[$];
    logic [23:0] log_addr[$];
    logic [7:0]  log_mode[$];

    assign flash_dq_in = drive_en ? drive_nib : 4'h0;

    always @(negedge flash_ce_n) begin
        rises    = 0;
        m_cmd    = 8'h0;
        m_addr   = 24'h0;
        m_mode   = 8'h0;
        drive_en = 1'b0;
    end

    always @(posedge flash_ce_n) begin
        drive_en = 1'b0;
        log_edges.push_back(rises);
        log_cmd.push_back(m_cmd);
        log_addr.push_back(m_addr);
        log_mode.push_back(m_mode);
    end

    always @(posedge flash_sclk) begin
        if (!flash_ce_n) begin
            if (rises < 8) m_cmd = {m_cmd[6:0], flash_dq_out[0]};
            else if (rises < 14) m_addr = {m_addr[19:0], flash_dq_out};
            else if (rises < 16) m_mode = {m_mode[3:0], flash_dq_out};
            rises++;
        end
    end

    always @(negedge flash_sclk) begin
        int n;
        logic [7:0] b;
        if (!flash_ce_n && !reset && rises >= 16 + DUMMY) begin
            n = rises - (16 + DUMMY);
            b = mem_byte(m_addr + 24'(n >> 1));
            drive_nib = n[0] ? b[3:0] : b[7:4];
            drive_en  = 1'b1;
        end
    end

    // Scoreboard and bus monitor.
    logic [7:0] exp_q[$];
    int n_rd = 0;
    int n_done = 0;
    int n_cont = 0;
    int n_ce_fall = 0;
    int hi_run = 0;
    int last_gap = 0;
    int done_hi = 0;

    always @(negedge clk) begin
        if (flash_ce_n === 1'b1) begin
            hi_run++;
        end else begin
            if (hi_run != 0) begin
                last_gap = hi_run;
                n_ce_fall++;
            end
            hi_run = 0;
        end
        if (done === 1'b1) begin
            n_done++;
            done_hi = hi_run;
        end
        if (rd_valid === 1'b1) begin
            n_rd++;
            if (exp_q.size() == 0) chk("rd_extra", 1, 0);
            else chk("rd_data", rd_data, exp_q.pop_front());
        end
        if (drive_en && flash_dq_oe != 4'h0) n_cont++;
    end

    task automatic issue(input logic [23:0] a, input logic [15:0] l);
        int t = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        while (!req_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        for (int i = 0; i < int'(l); i++) exp_q.push_back(mem_byte(a + 24'(i)));
        @(negedge clk);
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (n_done < target && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", 32'(n_done >= target), 1);
    endtask

    task automatic check_txn(input logic [23:0] a, input int len);
        if (log_edges.size() == 0) begin
            chk("txn_log", 0, 1);
            return;
        end
        chk("sclk_edges", log_edges.pop_front(), 16 + DUMMY + 2 * len);
        chk("cmd", log_cmd.pop_front(), 8'hEB);
        chk("addr", log_addr.pop_front(), a);
        chk("mode", log_mode.pop_front(), 8'h00);
    endtask

    task automatic clear_logs();
        log_edges.delete();
        log_cmd.delete();
        log_addr.delete();
        log_mode.delete();
    endtask

    task automatic read_txn(input logic [23:0] a, input int len);
        int d0, r0, f0;
        d0 = n_done;
        r0 = n_rd;
        f0 = n_ce_fall;
        issue(a, 16'(len));
        if (len == 0) begin
            chk("len0_done", done, 1);
            chk("len0_ce_n", flash_ce_n, 1);
        end else begin
            chk("ce_latency", flash_ce_n, 0);
        end
        req_valid = 1'b0;
        wait_done(d0 + 1);
        repeat (10) @(negedge clk);
        chk("done_count", n_done - d0, 1);
        chk("rd_count", n_rd - r0, len);
        chk("exp_empty", exp_q.size(), 0);
        if (len == 0) chk("len0_no_ce", n_ce_fall - f0, 0);
        else check_txn(a, len);
    endtask

    initial begin
        int idle_bad;
        int d0, r0, t;
        logic [23:0] a;
        int len;

        seed      = 8'($urandom);
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 24'h0;
        req_len   = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        clear_logs();

        idle_bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (flash_ce_n !== 1'b1 || flash_sclk !== 1'b0 ||
                flash_dq_oe !== 4'h0 || req_ready !== 1'b1 ||
                busy !== 1'b0) idle_bad++;
        end
        chk("idle_stable", idle_bad, 0);
        chk("idle_ce_n", flash_ce_n, 1);
        chk("idle_ready", req_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_dq_out", flash_dq_out, 4'h0);

        read_txn(24'h123456, 1);
        chk("done_after_gap", done_hi, CS_GAP);
        read_txn(24'hFFFFFE, 4);
        read_txn(24'h000040, 0);

        // Abort a len=8 read mid-DATA.
        d0 = n_done;
        r0 = n_rd;
        issue(24'h000100, 16'd8);
        req_valid = 1'b0;
        t = 0;
        while (n_rd < r0 + 2 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("abort_in_data", 32'(n_rd >= r0 + 2), 1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_ce_n", flash_ce_n, 1);
        chk("abort_dq_oe", flash_dq_oe, 4'h0);
        chk("abort_sclk", flash_sclk, 0);
        chk("abort_busy", busy, 0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        clear_logs();
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_done", n_done - d0, 0);
        read_txn(24'(($urandom)), 2);

        // Back-to-back with req_valid held high.
        d0 = n_done;
        issue(24'h0ABCDE, 16'd3);
        issue(24'h300000, 16'd2);
        req_valid = 1'b0;
        wait_done(d0 + 2);
        repeat (10) @(negedge clk);
        chk("b2b_done_count", n_done - d0, 2);
        chk("b2b_exp_empty", exp_q.size(), 0);
        check_txn(24'h0ABCDE, 3);
        check_txn(24'h300000, 2);
        chk("b2b_cs_gap", 32'(last_gap >= CS_GAP), 1);

        for (int i = 0; i < 8; i++) begin
            a = 24'($urandom);
            if ($urandom_range(0, 2) == 0) a = 24'hFFFFFF - 24'($urandom_range(0, 3));
            len = int'($urandom_range(0, 6));
            read_txn(a, len);
        end

        chk("dq_contention", n_cont, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
